pc_redirect_ctrl: RTL

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer with branch/trap redirect handling.
//
// Holds the fetch PC, advances it by 4 when the fetch is accepted and the
// pipeline is not stalled, and steers it to a redirect target. Traps take
// priority over branches. A redirect that arrives while instruction memory is
// not ready is parked in a pending register (HOLD state) until if_ready rises.
// While parked, further traps overwrite the parked target. Branches are dropped
// because they come from wrong-path instructions.
//
// Optional feature: define PC_REDIRECT_CNT_EN to build the saturating
// br_cnt/trap_cnt event counters. When it is undefined the ports remain and are
// tied to zero.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   br_redirect, br_target   EX-stage taken branch/jump and its target
//   trap_redirect, trap_target  CSR trap entry / xRET and its target
//   if_ready                 instruction memory accepts the current request
//   id_stall                 load-use stall from the hazard unit
//   pc, if_valid             fetch request
//   flush_if, flush_id, flush_ex  pipeline-register kill strobes
//   redirect_pending         a parked redirect is waiting for if_ready
//   br_cnt, trap_cnt         redirect event counters
module pc_redirect_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_redirect,
  input  logic [63:0] br_target,
  input  logic        trap_redirect,
  input  logic [63:0] trap_target,
  input  logic        if_ready,
  input  logic        id_stall,
  output logic [63:0] pc,
  output logic        if_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        redirect_pending,
  output logic [31:0] br_cnt,
  output logic [31:0] trap_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_q, pend_d;
  logic        redirect;
  logic [63:0] target;
  logic        flush_front;

  assign redirect = trap_redirect | br_redirect;
  assign target   = trap_redirect ? trap_target : br_target;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pend_d           = pend_q;
    if_valid         = 1'b0;
    redirect_pending = 1'b0;
    flush_front      = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if_valid = 1'b1;
        if (redirect) begin
          // Stall is irrelevant once the younger instructions are killed.
          flush_front = 1'b1;
          if (if_ready) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = StHold;
          end
        end else if (if_ready && !id_stall) begin
          pc_d = pc_q + 64'd4;
        end
      end
      StHold: begin
        if_valid         = 1'b1;
        redirect_pending = 1'b1;
        // Branches seen here are wrong-path and are dropped.
        if (trap_redirect) begin
          pend_d      = trap_target;
          flush_front = 1'b1;
        end
        if (if_ready) begin
          pc_d        = trap_redirect ? trap_target : pend_q;
          state_d     = StRun;
          flush_front = 1'b1;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
    if (rst) begin
      if_valid         = 1'b0;
      redirect_pending = 1'b0;
      flush_front      = 1'b0;
    end
  end

  assign flush_if = flush_front;
  assign flush_id = flush_front;
  assign flush_ex = trap_redirect & ~rst;
  assign pc       = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      pend_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] br_cnt_q, trap_cnt_q;
  logic        br_accept;

  // Only a branch that wins priority in RUN is a real redirect.
  assign br_accept = br_redirect & ~trap_redirect & (state_q == StRun);

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q   <= 32'h0;
      trap_cnt_q <= 32'h0;
    end else begin
      if (br_accept && (br_cnt_q != 32'hFFFF_FFFF)) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (trap_redirect && (trap_cnt_q != 32'hFFFF_FFFF)) begin
        trap_cnt_q <= trap_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt   = br_cnt_q;
  assign trap_cnt = trap_cnt_q;
`else
  assign br_cnt   = 32'h0;
  assign trap_cnt = 32'h0;
`endif

endmodule
